// File: rtl/osc_meter_pkg.sv
// Shared types and helpers for the oscillator frequency meter:
// measurement FSM states, default widths and a saturating increment.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_e;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned GATE_W_DEF = 20;

  // Increments val, holding at max_val once it is reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for an asynchronous oscillator input followed by a
// third flop for rising-edge detection in the clk domain.
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;

  always_comb begin
    sync1_d = async_i;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts rising edges of two divided ring-oscillator signals over a gate window
// of GATE_CYCLES clk cycles and latches both counts plus their signed difference.
// Define OSC_FREQ_METER_CONT_EN to allow DONE to re-arm directly while start is held.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GATE_W      = GATE_W_DEF,
  parameter int unsigned GATE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_a,
  input  logic             osc_b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W:0]   diff,
  output logic             ovf_a,
  output logic             ovf_b
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   run_a_q, run_a_d, run_b_q, run_b_d;
  logic               run_ovf_a_q, run_ovf_a_d, run_ovf_b_q, run_ovf_b_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W:0]     diff_q, diff_d;
  logic               ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic               valid_q, valid_d;

  logic               rise_a, rise_b;
  logic [CNT_W-1:0]   acc_a, acc_b;
  logic               acc_ovf_a, acc_ovf_b;

  osc_edge_sync u_sync_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_a),
    .rise_o  (rise_a)
  );

  osc_edge_sync u_sync_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_b),
    .rise_o  (rise_b)
  );

  // Running values including this cycle's edges; the last gate cycle latches these.
  always_comb begin
    acc_a     = rise_a ? CNT_W'(sat_inc(32'(run_a_q), 32'(CNT_MAX))) : run_a_q;
    acc_b     = rise_b ? CNT_W'(sat_inc(32'(run_b_q), 32'(CNT_MAX))) : run_b_q;
    acc_ovf_a = run_ovf_a_q | (acc_a == CNT_MAX);
    acc_ovf_b = run_ovf_b_q | (acc_b == CNT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    run_a_d     = run_a_q;
    run_b_d     = run_b_q;
    run_ovf_a_d = run_ovf_a_q;
    run_ovf_b_d = run_ovf_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    diff_d      = diff_q;
    ovf_a_d     = ovf_a_q;
    ovf_b_d     = ovf_b_q;
    valid_d     = valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = GATE;
          gate_cnt_d  = GATE_LOAD;
          run_a_d     = '0;
          run_b_d     = '0;
          run_ovf_a_d = 1'b0;
          run_ovf_b_d = 1'b0;
          valid_d     = 1'b0;
        end
      end
      GATE: begin
        run_a_d     = acc_a;
        run_b_d     = acc_b;
        run_ovf_a_d = acc_ovf_a;
        run_ovf_b_d = acc_ovf_b;
        if (gate_cnt_q == '0) begin
          state_d = DONE;
          cnt_a_d = acc_a;
          cnt_b_d = acc_b;
          diff_d  = {1'b0, acc_a} - {1'b0, acc_b};
          ovf_a_d = acc_ovf_a;
          ovf_b_d = acc_ovf_b;
          valid_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef OSC_FREQ_METER_CONT_EN
        // Re-arm without an IDLE cycle; results stay valid until overwritten.
        if (start) begin
          state_d     = GATE;
          gate_cnt_d  = GATE_LOAD;
          run_a_d     = '0;
          run_b_d     = '0;
          run_ovf_a_d = 1'b0;
          run_ovf_b_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      run_a_q     <= '0;
      run_b_q     <= '0;
      run_ovf_a_q <= 1'b0;
      run_ovf_b_q <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      diff_q      <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      run_a_q     <= run_a_d;
      run_b_q     <= run_b_d;
      run_ovf_a_q <= run_ovf_a_d;
      run_ovf_b_q <= run_ovf_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      diff_q      <= diff_d;
      ovf_a_q     <= ovf_a_d;
      ovf_b_q     <= ovf_b_d;
      valid_q     <= valid_d;
    end
  end

  assign busy  = (state_q == GATE);
  assign done  = (state_q == DONE);
  assign valid = valid_q;
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
  assign diff  = diff_q;
  assign ovf_a = ovf_a_q;
  assign ovf_b = ovf_b_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: three instances (wide, narrow-saturating, short gate)
// share oscillator stimulus; expected counts come from a per-cycle input history.
module tb_osc_freq_meter;

  localparam int unsigned G_M  = 100;
  localparam int unsigned G_R  = 10;
  localparam int unsigned W_M  = 16;
  localparam int unsigned W_S  = 4;
  localparam int unsigned NCYC = 8192;
`ifdef OSC_FREQ_METER_CONT_EN
  localparam int unsigned REP_P = G_R + 1;
  localparam bit          CONT  = 1'b1;
`else
  localparam int unsigned REP_P = G_R + 2;
  localparam bit          CONT  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic osc_a = 1'b0;
  logic osc_b = 1'b0;
  logic start_m = 1'b0;
  logic start_r = 1'b0;

  logic busy_m, done_m, valid_m, ovf_a_m, ovf_b_m;
  logic [W_M-1:0] cnt_a_m, cnt_b_m;
  logic [W_M:0]   diff_m;
  logic busy_s, done_s, valid_s, ovf_a_s, ovf_b_s;
  logic [W_S-1:0] cnt_a_s, cnt_b_s;
  logic [W_S:0]   diff_s;
  logic busy_r, done_r, valid_r, ovf_a_r, ovf_b_r;
  logic [W_M-1:0] cnt_a_r, cnt_b_r;
  logic [W_M:0]   diff_r;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned per_a = 0, per_b = 0, ph_a = 0, ph_b = 0;
  bit ha [NCYC];
  bit hb [NCYC];

  osc_freq_meter #(.CNT_W(W_M), .GATE_W(20), .GATE_CYCLES(G_M)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .osc_a(osc_a), .osc_b(osc_b), .start(start_m),
    .busy(busy_m), .done(done_m), .valid(valid_m), .cnt_a(cnt_a_m), .cnt_b(cnt_b_m),
    .diff(diff_m), .ovf_a(ovf_a_m), .ovf_b(ovf_b_m)
  );

  osc_freq_meter #(.CNT_W(W_S), .GATE_W(20), .GATE_CYCLES(G_M)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .osc_a(osc_a), .osc_b(osc_b), .start(start_m),
    .busy(busy_s), .done(done_s), .valid(valid_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s),
    .diff(diff_s), .ovf_a(ovf_a_s), .ovf_b(ovf_b_s)
  );

  osc_freq_meter #(.CNT_W(W_M), .GATE_W(20), .GATE_CYCLES(G_R)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .osc_a(osc_a), .osc_b(osc_b), .start(start_r),
    .busy(busy_r), .done(done_r), .valid(valid_r), .cnt_a(cnt_a_r), .cnt_b(cnt_b_r),
    .diff(diff_r), .ovf_a(ovf_a_r), .ovf_b(ovf_b_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // per 0: held low, 1: random level each cycle, else square wave of that period.
  function automatic bit osc_val(input int unsigned per, input int unsigned ph);
    if (per == 0) return 1'b0;
    if (per == 1) return 1'($urandom_range(0, 1));
    return ((cyc + ph) % per) < (per / 2);
  endfunction

  // Inputs set in cycle n are sampled at the following edge; history indexed by n.
  task automatic tick();
    @(negedge clk);
    osc_a = osc_val(per_a, ph_a);
    osc_b = osc_val(per_b, ph_b);
    ha[cyc] = osc_a;
    hb[cyc] = osc_b;
  endtask

  // A rise on the pin in cycle n is counted if the meter is gating in cycle n+2.
  function automatic int unsigned rises(input bit which_b, input int unsigned ws, input int unsigned we);
    int unsigned n = 0;
    for (int unsigned c = ws; c <= we; c++) begin
      if (which_b ? (hb[c-2] && !hb[c-3]) : (ha[c-2] && !ha[c-3])) n++;
    end
    return n;
  endfunction

  task automatic check_result(input string tag, input int unsigned d, input int unsigned g,
                              input int unsigned w, input logic [31:0] ca, input logic [31:0] cb,
                              input logic [31:0] df, input logic oa, input logic ob, input logic v);
    int unsigned ra, rb, mx, ea, eb;
    ra = rises(1'b0, d - g, d - 1);
    rb = rises(1'b1, d - g, d - 1);
    mx = (32'd1 << w) - 1;
    ea = (ra > mx) ? mx : ra;
    eb = (rb > mx) ? mx : rb;
    check_eq({tag, ".cnt_a"}, ca, ea);
    check_eq({tag, ".cnt_b"}, cb, eb);
    check_eq({tag, ".diff"}, df, (ea - eb) & ((32'd1 << (w + 1)) - 1));
    check_eq({tag, ".ovf_a"}, 32'(oa), 32'(ra >= mx));
    check_eq({tag, ".ovf_b"}, 32'(ob), 32'(rb >= mx));
    check_eq({tag, ".valid"}, 32'(v), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".m.flags"}, 32'({busy_m, done_m, valid_m, ovf_a_m, ovf_b_m}), 32'd0);
    check_eq({tag, ".m.cnt"}, 32'({cnt_a_m, cnt_b_m}), 32'd0);
    check_eq({tag, ".m.diff"}, 32'(diff_m), 32'd0);
    check_eq({tag, ".s.flags"}, 32'({busy_s, done_s, valid_s, ovf_a_s, ovf_b_s}), 32'd0);
    check_eq({tag, ".s.cnt"}, 32'({cnt_a_s, cnt_b_s}), 32'd0);
    check_eq({tag, ".s.diff"}, 32'(diff_s), 32'd0);
    check_eq({tag, ".r.flags"}, 32'({busy_r, done_r, valid_r, ovf_a_r, ovf_b_r}), 32'd0);
    check_eq({tag, ".r.cnt"}, 32'({cnt_a_r, cnt_b_r}), 32'd0);
    check_eq({tag, ".r.diff"}, 32'(diff_r), 32'd0);
  endtask

  // One start pulse to the G_M instances; optional extra starts while gating.
  task automatic meas(input int unsigned pa, input int unsigned pb, input bit extra);
    int unsigned t0;
    per_a = pa;
    per_b = pb;
    ph_a  = $urandom_range(0, 15);
    ph_b  = $urandom_range(0, 15);
    repeat (6) tick();
    start_m = 1'b1;
    t0 = cyc;
    for (int unsigned k = 1; k <= G_M + 3; k++) begin
      tick();
      start_m = extra && (k < G_M) && ($urandom_range(0, 3) == 0);
      check_eq("m.busy", 32'(busy_m), 32'(k <= G_M));
      check_eq("s.busy", 32'(busy_s), 32'(k <= G_M));
      check_eq("m.done", 32'(done_m), 32'(k == G_M + 1));
      check_eq("s.done", 32'(done_s), 32'(k == G_M + 1));
      check_eq("m.valid", 32'(valid_m), 32'(k > G_M));
      if (k == G_M + 1) begin
        check_result("m", cyc, G_M, W_M, 32'(cnt_a_m), 32'(cnt_b_m), 32'(diff_m), ovf_a_m, ovf_b_m, valid_m);
        check_result("s", cyc, G_M, W_S, 32'(cnt_a_s), 32'(cnt_b_s), 32'(diff_s), ovf_a_s, ovf_b_s, valid_s);
      end
    end
    start_m = 1'b0;
  endtask

  // start held high on the short-gate instance: periodic done, valid behaviour per build.
  task automatic rep_test();
    int unsigned t0, first, c, ph;
    bit exp_done, exp_busy, exp_valid;
    per_a = 3;
    per_b = $urandom_range(1, 7);
    repeat (6) tick();
    start_r = 1'b1;
    t0 = cyc;
    first = t0 + G_R + 1;
    for (int unsigned k = 1; k <= 70; k++) begin
      tick();
      c = cyc;
      ph = (c >= first) ? (c - first) % REP_P : 0;
      exp_done  = (c >= first) && (ph == 0);
      exp_valid = (c >= first) && (CONT || ph <= 1);
      exp_busy  = !((c >= first) && (ph == 0 || (!CONT && ph == 1)));
      check_eq("r.done", 32'(done_r), 32'(exp_done));
      check_eq("r.busy", 32'(busy_r), 32'(exp_busy));
      check_eq("r.valid", 32'(valid_r), 32'(exp_valid));
      if (exp_done)
        check_result("r", c, G_R, W_M, 32'(cnt_a_r), 32'(cnt_b_r), 32'(diff_r), ovf_a_r, ovf_b_r, valid_r);
    end
    start_r = 1'b0;
    repeat (30) tick();
  endtask

  task automatic reset_test();
    per_a = 2;
    per_b = 3;
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (30) tick();
    #3 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("rst_rel.busy", 32'(busy_m), 32'd0);
    check_eq("rst_rel.valid", 32'(valid_m), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("rst_init");
    rst_n = 1'b1;
    meas(4, 5, 1'b0);
    meas(2, 0, 1'b0);
    meas(0, 4, 1'b1);
    for (int i = 0; i < 4; i++)
      meas($urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    rep_test();
    reset_test();
    meas(3, 7, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
